sound_mix_sequencer: RTL and testbench
======================================

Name: sound_mix_sequencer

Overview:
- Time-multiplexed mixing controller for the sound path. It sums COUNT signed channels with per-channel gain using one multiply-accumulate unit, sequenced by a state machine.
- Triggered once per sample period by SAMPLE_STB. Produces a saturated BIT_WIDTH result with a valid pulse, suitable for a downstream attenuator or output stage.
- Gains are configured through a simple register write port.

Parameters:
- COUNT, 4, number of input channels (>=1)
- BIT_WIDTH, 10, signed sample width, input and output
- GAIN_WIDTH, 4, unsigned gain width; unity gain = 2^(GAIN_WIDTH-1)

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  reset
- SAMPLE_STB  in  1  start-of-sample pulse
- IN_SIGNAL  in  COUNT*BIT_WIDTH  channel ch at [ch*BIT_WIDTH +: BIT_WIDTH], two's complement
- GAIN_WE  in  1  gain write strobe
- GAIN_SEL  in  max(1,$clog2(COUNT))  channel index for the write; values >= COUNT are ignored
- GAIN_DATA  in  GAIN_WIDTH  gain value
- BUSY  out  1  high while a sample is in progress
- OUT_SIGNAL  out  BIT_WIDTH  mixed, saturated result; held between updates
- OUT_VALID  out  1  one-cycle pulse when OUT_SIGNAL updates
- CLIP  out  1  qualified by OUT_VALID: result was saturated
- OVERRUN  out  1  one-cycle pulse when SAMPLE_STB arrives while BUSY

Behaviour:
- Clocking and reset: one clock, CLK. RESET_n is asynchronous, active-low.
- Reset values: OUT_SIGNAL=0, OUT_VALID=0, CLIP=0, OVERRUN=0, BUSY=0. State=IDLE. All gain registers = unity (8 at defaults).
- Gain registers: written on GAIN_WE at the clock edge; they take effect from the next accepted strobe. If GAIN_WE and SAMPLE_STB occur in the same cycle, the snapshot takes the newly written value (write-through).
- States: IDLE, ACCUM, LIMIT.
- IDLE: on SAMPLE_STB, snapshot all IN_SIGNAL lanes and all gains. Then acc=0, idx=0, BUSY=1, go to ACCUM.
- ACCUM: one channel per cycle, acc += sext(snap[idx]) * gain[idx] (signed by unsigned). idx++. When idx==COUNT-1 has been processed, go to LIMIT.
- LIMIT:
  - t = acc >>> (GAIN_WIDTH-1), arithmetic shift that truncates toward -inf.
  - Saturate t to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
  - Register OUT_SIGNAL. Pulse OUT_VALID. CLIP=1 if clamped, otherwise 0.
  - BUSY=0, go to IDLE.
- Accumulator width: BIT_WIDTH+GAIN_WIDTH+$clog2(COUNT+1). It never wraps internally.
- Latency: strobe sampled at edge t gives OUT_VALID high in cycle t+COUNT+1. The minimum strobe spacing without overrun is COUNT+2 cycles.
- SAMPLE_STB while BUSY: strobe ignored, the sample in progress is unaffected, OVERRUN pulses for one cycle.
- IN_SIGNAL may change freely after the snapshot.
- RESET_n asserted mid-operation: abort immediately. No OUT_VALID is produced. All registers return to their reset values, including gains.
- CLIP is only meaningful on OUT_VALID. It holds its value otherwise.

Optional Feature:
- Macro: SOUND_MIX_SEQ_GAIN_RAMP_EN
- Defined:
  - GAIN_DATA writes set a per-channel target register.
  - Each effective gain steps by ±1 toward its target on every accepted SAMPLE_STB, before the snapshot. The snapshot uses the stepped value.
  - Reset: target = effective = unity.
  - This gives zipper-free gain changes.
- Undefined: no target registers; writes set the effective gain directly, as described in Behaviour.

Test Plan (COUNT=4, BIT_WIDTH=10, GAIN_WIDTH=4):
- Reset, then inputs {100,-50,20,0}, STB at cycle t. Required: BUSY high in t+1..t+4, OUT_VALID at t+5, OUT_SIGNAL=70, CLIP=0.
- All inputs 400, unity gains. Required: OUT_SIGNAL=511, CLIP=1. All inputs -400. Required: OUT_SIGNAL=-512, CLIP=1.
- Write gain ch0=4 and ch1=0. Inputs {101,300,0,0}. Required: OUT_SIGNAL=50. Same gains with inputs {-101,300,0,0}. Required: OUT_SIGNAL=-51.
- STB at t and at t+2. Required: OVERRUN pulse at t+2, exactly one OUT_VALID (at t+5). Same-cycle GAIN_WE ch0=0 with STB, inputs {200,0,0,0}. Required: OUT_SIGNAL=0.
- RESET_n low at t+2 after STB. Required: no OUT_VALID, outputs 0. Next sample uses unity gains.
- With SOUND_MIX_SEQ_GAIN_RAMP_EN: write ch0 target 12, inputs {80,0,0,0}, four strobes. Required: OUT_SIGNAL 90, 100, 110, 120, then 120 steady.

Source files
------------

// File: rtl/sound_mix_sequencer_if.sv
// Bus bundle for sound_mix_sequencer: sample strobe, channel lanes,
// gain write port and the mixed result with its status flags.
interface sound_mix_sequencer_if #(
  parameter int unsigned COUNT      = 4,
  parameter int unsigned BIT_WIDTH  = 10,
  parameter int unsigned GAIN_WIDTH = 4
);
  localparam int unsigned SEL_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic                         SAMPLE_STB;
  logic [COUNT*BIT_WIDTH-1:0]   IN_SIGNAL;
  logic                         GAIN_WE;
  logic [SEL_W-1:0]             GAIN_SEL;
  logic [GAIN_WIDTH-1:0]        GAIN_DATA;
  logic                         BUSY;
  logic [BIT_WIDTH-1:0]         OUT_SIGNAL;
  logic                         OUT_VALID;
  logic                         CLIP;
  logic                         OVERRUN;

  modport master (
    output SAMPLE_STB, IN_SIGNAL, GAIN_WE, GAIN_SEL, GAIN_DATA,
    input  BUSY, OUT_SIGNAL, OUT_VALID, CLIP, OVERRUN
  );

  modport slave (
    input  SAMPLE_STB, IN_SIGNAL, GAIN_WE, GAIN_SEL, GAIN_DATA,
    output BUSY, OUT_SIGNAL, OUT_VALID, CLIP, OVERRUN
  );
endinterface

// File: rtl/sound_mix_sequencer.sv
// Time-multiplexed gain mixer: one MAC per channel per cycle, then shift and saturate.
// Define SOUND_MIX_SEQ_GAIN_RAMP_EN to make gain writes ramp by +/-1 per accepted strobe.
module sound_mix_sequencer #(
  parameter int unsigned COUNT      = 4,
  parameter int unsigned BIT_WIDTH  = 10,
  parameter int unsigned GAIN_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  sound_mix_sequencer_if.slave   bus
);
  localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned ACC_W = BIT_WIDTH + GAIN_WIDTH + $clog2(COUNT + 1);
  localparam int unsigned SHIFT = GAIN_WIDTH - 1;
  localparam logic [GAIN_WIDTH-1:0]   UNITY   = GAIN_WIDTH'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (BIT_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LIMIT} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [BIT_WIDTH-1:0]   snap_q [COUNT];
  logic signed [BIT_WIDTH-1:0]   snap_d [COUNT];
  logic [GAIN_WIDTH-1:0]         gsnap_q [COUNT];
  logic [GAIN_WIDTH-1:0]         gsnap_d [COUNT];
  logic [GAIN_WIDTH-1:0]         gain_q [COUNT];
  logic [GAIN_WIDTH-1:0]         gain_d [COUNT];
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
  logic [GAIN_WIDTH-1:0]         target_q [COUNT];
  logic [GAIN_WIDTH-1:0]         target_d [COUNT];
`endif
  logic                          busy_q, busy_d;
  logic [BIT_WIDTH-1:0]          out_sig_q, out_sig_d;
  logic                          out_valid_q, out_valid_d;
  logic                          clip_q, clip_d;
  logic                          overrun_q, overrun_d;

  logic signed [ACC_W-1:0]       samp_ext;
  logic signed [ACC_W-1:0]       gain_ext;
  logic signed [ACC_W-1:0]       shifted;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    snap_d      = snap_q;
    gsnap_d     = gsnap_q;
    gain_d      = gain_q;
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
    target_d    = target_q;
`endif
    busy_d      = busy_q;
    out_sig_d   = out_sig_q;
    out_valid_d = 1'b0;
    clip_d      = clip_q;
    overrun_d   = 1'b0;

    // Signed sample times unsigned gain, both widened to the accumulator.
    samp_ext = ACC_W'(snap_q[idx_q]);
    gain_ext = ACC_W'(gsnap_q[idx_q]);
    shifted  = acc_q >>> SHIFT;

    if (bus.GAIN_WE && (32'(bus.GAIN_SEL) < COUNT)) begin
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
      target_d[bus.GAIN_SEL] = bus.GAIN_DATA;
`else
      gain_d[bus.GAIN_SEL] = bus.GAIN_DATA;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.SAMPLE_STB) begin
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
          for (int unsigned i = 0; i < COUNT; i++) begin
            if (gain_q[i] < target_d[i])      gain_d[i] = gain_q[i] + GAIN_WIDTH'(1);
            else if (gain_q[i] > target_d[i]) gain_d[i] = gain_q[i] - GAIN_WIDTH'(1);
          end
`endif
          // Snapshot sees same-cycle gain writes (write-through).
          for (int unsigned i = 0; i < COUNT; i++) begin
            snap_d[i]  = bus.IN_SIGNAL[i*BIT_WIDTH +: BIT_WIDTH];
            gsnap_d[i] = gain_d[i];
          end
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        overrun_d = bus.SAMPLE_STB;
        acc_d     = acc_q + samp_ext * gain_ext;
        idx_d     = idx_q + IDX_W'(1);
        if (32'(idx_q) == COUNT - 1) state_d = S_LIMIT;
      end
      S_LIMIT: begin
        overrun_d   = bus.SAMPLE_STB;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
        if (shifted > OUT_MAX) begin
          out_sig_d = BIT_WIDTH'(OUT_MAX);
          clip_d    = 1'b1;
        end else if (shifted < OUT_MIN) begin
          out_sig_d = BIT_WIDTH'(OUT_MIN);
          clip_d    = 1'b1;
        end else begin
          out_sig_d = BIT_WIDTH'(shifted);
          clip_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      for (int unsigned i = 0; i < COUNT; i++) begin
        snap_q[i]   <= '0;
        gsnap_q[i]  <= UNITY;
        gain_q[i]   <= UNITY;
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
        target_q[i] <= UNITY;
`endif
      end
      busy_q      <= 1'b0;
      out_sig_q   <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      snap_q      <= snap_d;
      gsnap_q     <= gsnap_d;
      gain_q      <= gain_d;
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
      target_q    <= target_d;
`endif
      busy_q      <= busy_d;
      out_sig_q   <= out_sig_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.BUSY       = busy_q;
  assign bus.OUT_SIGNAL = out_sig_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.CLIP       = clip_q;
  assign bus.OVERRUN    = overrun_q;
endmodule

// File: tb/tb_sound_mix_sequencer.sv
// Bench for sound_mix_sequencer: directed literal cases plus random traffic
// checked every cycle against a transaction-level mixing model.
module tb_sound_mix_sequencer;
  localparam int unsigned CNT   = 4;
  localparam int unsigned BW    = 10;
  localparam int unsigned GW    = 4;
  localparam int          UNITY = 2 ** (GW - 1);
  localparam int          MAXV  = 2 ** (BW - 1) - 1;
  localparam int          MINV  = -(2 ** (BW - 1));

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  bit   started;

  sound_mix_sequencer_if #(.COUNT(CNT), .BIT_WIDTH(BW), .GAIN_WIDTH(GW)) bus ();

  sound_mix_sequencer #(.COUNT(CNT), .BIT_WIDTH(BW), .GAIN_WIDTH(GW)) dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input logic [BW-1:0] v);
    logic signed [BW-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // Transaction-level model: a sample accepted at an edge yields its result
  // COUNT+1 edges later; strobes in between are overruns.
  int m_left;
  int m_gain   [CNT];
  int m_target [CNT];
  int m_out, m_clip, m_busy, m_valid, m_ovr;
  int m_res, m_res_clip, m_sum;
  logic signed [BW-1:0] m_lane;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; m_busy = 0; m_valid = 0; m_ovr = 0; m_clip = 0; m_out = 0;
        for (int i = 0; i < CNT; i++) begin
          m_gain[i] = UNITY;
          m_target[i] = UNITY;
        end
      end else begin
        m_valid = 0;
        m_ovr   = 0;
        if (bus.GAIN_WE && int'(bus.GAIN_SEL) < CNT) begin
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
          m_target[int'(bus.GAIN_SEL)] = int'(bus.GAIN_DATA);
`else
          m_gain[int'(bus.GAIN_SEL)] = int'(bus.GAIN_DATA);
`endif
        end
        if (m_left > 0) begin
          if (bus.SAMPLE_STB) m_ovr = 1;
          m_left--;
          if (m_left == 0) begin
            m_busy = 0; m_valid = 1; m_out = m_res; m_clip = m_res_clip;
          end
        end else if (bus.SAMPLE_STB) begin
`ifdef SOUND_MIX_SEQ_GAIN_RAMP_EN
          for (int i = 0; i < CNT; i++) begin
            if (m_gain[i] < m_target[i]) m_gain[i]++;
            else if (m_gain[i] > m_target[i]) m_gain[i]--;
          end
`endif
          m_sum = 0;
          for (int i = 0; i < CNT; i++) begin
            m_lane = bus.IN_SIGNAL[i*BW +: BW];
            m_sum += int'(m_lane) * m_gain[i];
          end
          m_res = m_sum / UNITY;
          if ((m_sum % UNITY) != 0 && m_sum < 0) m_res--;
          m_res_clip = 0;
          if (m_res > MAXV) begin m_res = MAXV; m_res_clip = 1; end
          if (m_res < MINV) begin m_res = MINV; m_res_clip = 1; end
          m_left = CNT + 1;
          m_busy = 1;
        end
      end
    end
  end

  // Cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("busy",    int'(bus.BUSY),      m_busy);
        check("valid",   int'(bus.OUT_VALID), m_valid);
        check("overrun", int'(bus.OVERRUN),   m_ovr);
        check("out",     sval(bus.OUT_SIGNAL), m_out);
        check("clip",    int'(bus.CLIP),      m_clip);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int a, input int b, input int c, input int d);
    bus.IN_SIGNAL = {BW'(d), BW'(c), BW'(b), BW'(a)};
  endtask

  task automatic strobe(input int a, input int b, input int c, input int d);
    set_lanes(a, b, c, d);
    bus.SAMPLE_STB = 1'b1;
    tick();
    bus.SAMPLE_STB = 1'b0;
    bus.IN_SIGNAL  = (CNT*BW)'({$urandom(), $urandom()});
  endtask

  task automatic write_gain(input int sel, input int val);
    bus.GAIN_WE   = 1'b1;
    bus.GAIN_SEL  = 2'(sel);
    bus.GAIN_DATA = GW'(val);
    tick();
    bus.GAIN_WE   = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp, input int exp_clip);
    int lat;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.OUT_VALID) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no OUT_VALID within 20 cycles", name);
    end else begin
      check({name, "_out"}, sval(bus.OUT_SIGNAL), exp);
      check({name, "_clip"}, int'(bus.CLIP), exp_clip);
    end
    tick();
  endtask

  initial begin
    int nvalid;
    n_tests = 0;
    n_fail  = 0;
    started = 1'b0;
    rst_n   = 1'b0;
    bus.SAMPLE_STB = 1'b0;
    bus.IN_SIGNAL  = '0;
    bus.GAIN_WE    = 1'b0;
    bus.GAIN_SEL   = '0;
    bus.GAIN_DATA  = '0;
    tick();
    started = 1'b1;
    tick();
    check("rst_out",   sval(bus.OUT_SIGNAL), 0);
    check("rst_busy",  int'(bus.BUSY), 0);
    check("rst_valid", int'(bus.OUT_VALID), 0);
    rst_n = 1'b1;
    tick();

    // Basic mix, latency and BUSY window.
    strobe(100, -50, 20, 0);
    for (int k = 1; k <= CNT + 2; k++) begin
      @(negedge clk);
      check("t1_busy",  int'(bus.BUSY), (k <= CNT + 1) ? 1 : 0);
      check("t1_valid", int'(bus.OUT_VALID), (k == CNT + 2) ? 1 : 0);
    end
    check("t1_out",  sval(bus.OUT_SIGNAL), 70);
    check("t1_clip", int'(bus.CLIP), 0);
    tick();

    strobe(400, 400, 400, 400);
    wait_result("sat_pos", 511, 1);
    strobe(-400, -400, -400, -400);
    wait_result("sat_neg", -512, 1);

`ifndef SOUND_MIX_SEQ_GAIN_RAMP_EN
    write_gain(0, 4);
    write_gain(1, 0);
    strobe(101, 300, 0, 0);
    wait_result("gain_pos", 50, 0);
    strobe(-101, 300, 0, 0);
    wait_result("gain_neg", -51, 0);

    // Second strobe two edges after the first.
    strobe(10, 0, 0, 0);
    tick();
    bus.SAMPLE_STB = 1'b1;
    tick();
    bus.SAMPLE_STB = 1'b0;
    @(negedge clk);
    check("ovr_pulse", int'(bus.OVERRUN), 1);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.OUT_VALID) nvalid++;
    end
    check("ovr_valids", nvalid, 1);
    tick();

    bus.GAIN_WE = 1'b1; bus.GAIN_SEL = 2'd0; bus.GAIN_DATA = GW'(0);
    strobe(200, 0, 0, 0);
    bus.GAIN_WE = 1'b0;
    wait_result("wthru", 0, 0);
`else
    write_gain(0, 12);
    strobe(80, 0, 0, 0);
    wait_result("ramp1", 90, 0);
    strobe(80, 0, 0, 0);
    wait_result("ramp2", 100, 0);
    strobe(80, 0, 0, 0);
    wait_result("ramp3", 110, 0);
    strobe(80, 0, 0, 0);
    wait_result("ramp4", 120, 0);
    strobe(80, 0, 0, 0);
    wait_result("ramp5", 120, 0);
`endif

    // Abort mid-sample.
    strobe(300, 300, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_out",  sval(bus.OUT_SIGNAL), 0);
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.OUT_VALID) nvalid++;
    end
    check("abort_novalid", nvalid, 0);
    tick();
    strobe(80, 80, 0, 0);
    wait_result("post_rst", 160, 0);

    // Random traffic: strobes, gain writes, occasional resets.
    for (int n = 0; n < 1500; n++) begin
      bus.IN_SIGNAL  = (CNT*BW)'({$urandom(), $urandom()});
      bus.SAMPLE_STB = ($urandom_range(0, 3) == 0);
      bus.GAIN_WE    = ($urandom_range(0, 4) == 0);
      bus.GAIN_SEL   = 2'($urandom_range(0, 3));
      bus.GAIN_DATA  = GW'($urandom_range(0, 15));
      rst_n          = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n          = 1'b1;
    bus.SAMPLE_STB = 1'b0;
    bus.GAIN_WE    = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
